// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

  // A word access is aligned when the two byte-offset bits are zero.
  function automatic logic is_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word-wide storage array: synchronous write, registered read, no reset.
module word_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  // Commit writes and register the read word on every rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder placed between the datapath memory
// port and the word storage; adds a fixed access latency so stall logic
// upstream sees realistic handshakes.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 3
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  byte_t [0:3]     mem_data_in,
  output byte_t [0:3]     mem_data_out,
  output logic            mem_ready,
  output logic            mem_err,
  output logic            busy
);

  localparam int WA = ADDR_BITS - 2;

  resp_state_t      r_state;
  resp_state_t      w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_we;
  logic             r_err;
  logic [WA-1:0]    r_addr;
  logic [XLEN-1:0]  r_wdata;
  logic [XLEN-1:0]  r_hold;

  logic             w_idle;
  logic             w_accept;
  logic             w_aligned;
  logic             w_commit;
  logic             w_ram_we;
  logic             w_load_resp;
  logic [WA-1:0]    w_addr;
  logic [XLEN-1:0]  w_din;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_rdata;
  logic             w_unused;

  // Address bits above the decoded range alias away by design.
  assign w_unused  = ^req_addr[XLEN-1:ADDR_BITS];

  assign w_idle    = (r_state == IDLE);
  assign w_accept  = w_idle && req_valid;
  assign w_aligned = is_aligned(req_addr[1:0]);
  assign w_din     = mem_data_in;

  // With LATENCY=1 the access happens on the accept edge, so the storage
  // must see the live request rather than the latched copy while idle.
  assign w_addr   = w_idle ? req_addr[ADDR_BITS-1:2] : r_addr;
  assign w_wdata  = w_idle ? w_din : r_wdata;
  assign w_ram_we = w_commit && (w_idle ? req_we : r_we);

  word_ram #(
    .AW(WA),
    .DW(XLEN)
  ) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .waddr(w_addr),
    .raddr(w_addr),
    .wdata(w_wdata),
    .rdata(w_rdata)
  );

  // Next-state, countdown and commit decision; the commit edge is the
  // one where the counter steps from 1 to 0.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_commit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (!w_aligned) begin
            w_next = RESP;
          end else if (LATENCY == 1) begin
            w_next   = RESP;
            w_commit = 1'b1;
          end else begin
            w_next     = WAIT;
            w_cnt_next = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_next   = RESP;
          w_commit = 1'b1;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State and countdown registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the request once at acceptance; later changes are ignored.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_err   <= !w_aligned;
      r_addr  <= req_addr[ADDR_BITS-1:2];
      r_wdata <= w_din;
    end
  end

  assign w_load_resp = (r_state == RESP) && !r_we && !r_err;

  // Keep the last good load result once the response cycle ends.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_hold <= '0;
    end else if (w_load_resp) begin
      r_hold <= w_rdata;
    end
  end

  assign mem_data_out = w_load_resp ? w_rdata : r_hold;
  assign mem_ready    = (r_state == RESP);
  assign mem_err      = (r_state == RESP) && r_err;
  assign busy         = !w_idle;

endmodule
